buffer_owner_ctrl: RTL

- Sequential controller that decides which agent owns each of the three packet buffers (ping, pang, pung) at every cycle.
- The three agents are the snooper, the CPU and the forwarder.
- Drives sn_sel, cpu_sel and fwd_sel straight into the packet-memory mux stage, which derives ping_sel, pang_sel and pung_sel from them.
- Packets rotate through the buffers in order: snooper fill -> CPU verdict -> forward, or drop.

---
 rtl/buffer_owner_ctrl_pkg.sv | 25 ++
 rtl/buffer_owner_ctrl_bufid_fifo2.sv | 56 +++++
 rtl/buffer_owner_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/buffer_owner_ctrl_pkg.sv
// Shared definitions for the packet-buffer ownership controller:
// select encoding, per-buffer state enum and buffer count.
package buffer_owner_ctrl_pkg;

    localparam int NUM_BUFS = 3;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_PING = 2'b01;
    localparam logic [1:0] SEL_PANG = 2'b10;
    localparam logic [1:0] SEL_PUNG = 2'b11;

    typedef enum logic [2:0] {
        ST_FREE,
        ST_SN,
        ST_CPUQ,
        ST_CPU,
        ST_FWDQ,
        ST_FWD
    } buf_st_e;

    function automatic logic [1:0] idx2sel(input int i);
        return 2'(i + 1);
    endfunction

endpackage

// File: rtl/buffer_owner_ctrl_bufid_fifo2.sv
// Two-entry FIFO of 2-bit buffer ids; push and pop may coincide.
// Pop on empty and push on full (without pop) are ignored.
module bufid_fifo2
    import buffer_owner_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] din,
    output logic [1:0] head,
    output logic       empty,
    output logic       full
);

    logic [1:0] head_q, head_d;
    logic [1:0] tail_q, tail_d;
    logic [1:0] cnt_q, cnt_d;
    logic       do_pop;
    logic       do_push;

    assign do_pop  = pop && (cnt_q != 2'd0);
    assign do_push = push && ((cnt_q != 2'd2) || do_pop);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (do_pop) begin
            head_d = tail_q;
            cnt_d  = cnt_q - 2'd1;
        end
        if (do_push) begin
            if (cnt_d == 2'd0) head_d = din;
            else               tail_d = din;
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= SEL_NONE;
            tail_q <= SEL_NONE;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head  = head_q;
    assign empty = (cnt_q == 2'd0);
    assign full  = (cnt_q == 2'd2);

endmodule

// File: rtl/buffer_owner_ctrl.sv
// Ownership controller rotating ping/pang/pung between snooper, CPU and forwarder.
// Optional statistics counters are enabled with BUFCTRL_STATS_EN.
module buffer_owner_ctrl
    import buffer_owner_ctrl_pkg::*;
#(
    parameter int STATS_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sn_done,
    input  logic       cpu_acc,
    input  logic       cpu_rej,
    input  logic       fwd_done,
    output logic [1:0] sn_sel,
    output logic [1:0] cpu_sel,
    output logic [1:0] fwd_sel,
    output logic       sn_rdy,
    output logic       cpu_rdy,
    output logic       fwd_rdy
`ifdef BUFCTRL_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] stat_accepted,
    output logic [STATS_WIDTH-1:0] stat_rejected,
    output logic [STATS_WIDTH-1:0] stat_sn_stall_cycles
`endif
);

    buf_st_e    st_q [NUM_BUFS];
    buf_st_e    st_d [NUM_BUFS];
    logic [1:0] sn_sel_q, sn_sel_d;
    logic [1:0] cpu_sel_q, cpu_sel_d;
    logic [1:0] fwd_sel_q, fwd_sel_d;

    logic       sn_fire, acc, rej, fwd_fire;
    logic       cpu_free, fwd_free;
    logic       cpu_bypass, fwd_bypass;
    logic       cq_push, cq_pop, cq_empty, cq_full;
    logic       fq_push, fq_pop, fq_empty, fq_full;
    logic [1:0] cq_head, fq_head;

    // Reject wins when the CPU raises both verdicts.
    assign sn_fire  = sn_done && sn_rdy;
    assign rej      = cpu_rej && cpu_rdy;
    assign acc      = cpu_acc && !cpu_rej && cpu_rdy;
    assign fwd_fire = fwd_done && fwd_rdy;

    assign cpu_free   = !cpu_rdy || acc || rej;
    assign fwd_free   = !fwd_rdy || fwd_fire;
    assign cpu_bypass = sn_fire && cpu_free && cq_empty;
    assign fwd_bypass = acc && fwd_free && fq_empty;
    assign cq_push    = sn_fire && !cpu_bypass;
    assign cq_pop     = cpu_free && !cq_empty;
    assign fq_push    = acc && !fwd_bypass;
    assign fq_pop     = fwd_free && !fq_empty;

    bufid_fifo2 u_cpu_q (
        .clk   (clk),
        .rst   (rst),
        .push  (cq_push),
        .pop   (cq_pop),
        .din   (sn_sel_q),
        .head  (cq_head),
        .empty (cq_empty),
        .full  (cq_full)
    );

    bufid_fifo2 u_fwd_q (
        .clk   (clk),
        .rst   (rst),
        .push  (fq_push),
        .pop   (fq_pop),
        .din   (cpu_sel_q),
        .head  (fq_head),
        .empty (fq_empty),
        .full  (fq_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q[0] <= ST_SN;
            for (int i = 1; i < NUM_BUFS; i++) st_q[i] <= ST_FREE;
            sn_sel_q  <= SEL_PING;
            cpu_sel_q <= SEL_NONE;
            fwd_sel_q <= SEL_NONE;
        end else begin
            st_q      <= st_d;
            sn_sel_q  <= sn_sel_d;
            cpu_sel_q <= cpu_sel_d;
            fwd_sel_q <= fwd_sel_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        sn_sel_d  = sn_sel_q;
        cpu_sel_d = cpu_sel_q;
        fwd_sel_d = fwd_sel_q;

        if (cpu_free) begin
            if (cq_pop)          cpu_sel_d = cq_head;
            else if (cpu_bypass) cpu_sel_d = sn_sel_q;
            else                 cpu_sel_d = SEL_NONE;
        end
        if (fwd_free) begin
            if (fq_pop)          fwd_sel_d = fq_head;
            else if (fwd_bypass) fwd_sel_d = cpu_sel_q;
            else                 fwd_sel_d = SEL_NONE;
        end

        for (int i = 0; i < NUM_BUFS; i++) begin
            if (rej && idx2sel(i) == cpu_sel_q)
                st_d[i] = ST_FREE;
            if (fwd_fire && idx2sel(i) == fwd_sel_q)
                st_d[i] = ST_FREE;
            if (sn_fire && idx2sel(i) == sn_sel_q)
                st_d[i] = cpu_bypass ? ST_CPU : ST_CPUQ;
            if (acc && idx2sel(i) == cpu_sel_q)
                st_d[i] = fwd_bypass ? ST_FWD : ST_FWDQ;
            if (cq_pop && idx2sel(i) == cq_head)
                st_d[i] = ST_CPU;
            if (fq_pop && idx2sel(i) == fq_head)
                st_d[i] = ST_FWD;
        end

        // Snooper grabs the lowest free buffer, including ones freed now.
        if (!sn_rdy || sn_fire) begin
            sn_sel_d = SEL_NONE;
            for (int i = NUM_BUFS - 1; i >= 0; i--)
                if (st_d[i] == ST_FREE) sn_sel_d = idx2sel(i);
        end
        for (int i = 0; i < NUM_BUFS; i++)
            if (sn_sel_d != SEL_NONE && idx2sel(i) == sn_sel_d)
                st_d[i] = ST_SN;
    end

    always_comb begin
        sn_sel  = sn_sel_q;
        cpu_sel = cpu_sel_q;
        fwd_sel = fwd_sel_q;
        sn_rdy  = (sn_sel_q != SEL_NONE);
        cpu_rdy = (cpu_sel_q != SEL_NONE);
        fwd_rdy = (fwd_sel_q != SEL_NONE);
    end

`ifdef BUFCTRL_STATS_EN
    localparam logic [STATS_WIDTH-1:0] SAT = '1;

    logic [STATS_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
    logic [STATS_WIDTH-1:0] rej_cnt_q, rej_cnt_d;
    logic [STATS_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        acc_cnt_d   = acc_cnt_q;
        rej_cnt_d   = rej_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (acc && acc_cnt_q != SAT)
            acc_cnt_d = acc_cnt_q + 1'b1;
        if (rej && rej_cnt_q != SAT)
            rej_cnt_d = rej_cnt_q + 1'b1;
        if (!sn_rdy && stall_cnt_q != SAT)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt_q   <= '0;
            rej_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            acc_cnt_q   <= acc_cnt_d;
            rej_cnt_q   <= rej_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_accepted        = acc_cnt_q;
    assign stat_rejected        = rej_cnt_q;
    assign stat_sn_stall_cycles = stall_cnt_q;
`endif

endmodule
